serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_if.sv | 33 +++
 rtl/serial_adder_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
// ============================================================================
// Module   : serial_adder_ctrl_if
// Purpose  : Request/response bundle for the bit-serial add/subtract unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial adder/subtractor, one shared full-adder cell, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  serial_adder_ctrl_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_w, done_w;

  logic fa_s, fa_co, last_bit;

  // The single full-adder cell shared by every bit position.
  assign fa_s     = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_co    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_bit = (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_w = 1'b0;
    done_w = 1'b0;
    case (state_q)
      S_RUN:   busy_w = 1'b1;
      S_DONE:  done_w = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == S_IDLE && bus.start) begin
      // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d                = a_q >> 1;
      b_d                = b_q >> 1;
      carry_d            = fa_co;
      cnt_d              = cnt_q + CNT_W'(1);
      result_d           = result_q >> 1;
      result_d[WIDTH-1]  = fa_s;
      if (last_bit) begin
        cout_d = fa_co;
        ovf_d  = carry_q ^ fa_co;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = busy_w;
  assign bus.done     = done_w;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

`default_nettype wire
